// File: rtl/dct_pkg.sv
// Shared constants, typedefs and the zigzag scan table for the DCT coefficient path.
package dct_pkg;

  localparam int unsigned DCT_DATA_W = 12;
  localparam int unsigned DCT_N      = 8;
  localparam int unsigned DCT_BLK_SZ = DCT_N * DCT_N;

  typedef logic       bank_idx_t;
  typedef logic [5:0] scan_idx_t;

  typedef enum logic {ST_IDLE, ST_STREAM} rd_state_e;

  // Raster address {row, col} visited at each zigzag scan position.
  localparam scan_idx_t DCT_ZIGZAG [DCT_BLK_SZ] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

endpackage

// File: rtl/dct_zigzag_rom.sv
// Combinational zigzag lookup: scan position -> (row, col) of the 8x8 block.
module dct_zigzag_rom
  import dct_pkg::*;
(
  input  scan_idx_t  pos_i,
  output logic [2:0] row_o,
  output logic [2:0] col_o
);

  scan_idx_t addr;

  always_comb begin
    addr  = DCT_ZIGZAG[pos_i];
    row_o = addr[5:3];
    col_o = addr[2:0];
  end

endmodule

// File: rtl/dct_coef_serializer.sv
// Column-parallel to serial coefficient serializer with a ping-pong 2x64 block store.
// Define DCT_ZIGZAG_EN to emit in JPEG zigzag order instead of row-major raster order.
module dct_coef_serializer
  import dct_pkg::*;
#(
  parameter int unsigned DATA_W = DCT_DATA_W,
  parameter int unsigned N      = DCT_N
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  input  logic signed [DATA_W-1:0] i_data0,
  input  logic signed [DATA_W-1:0] i_data1,
  input  logic signed [DATA_W-1:0] i_data2,
  input  logic signed [DATA_W-1:0] i_data3,
  input  logic signed [DATA_W-1:0] i_data4,
  input  logic signed [DATA_W-1:0] i_data5,
  input  logic signed [DATA_W-1:0] i_data6,
  input  logic signed [DATA_W-1:0] i_data7,
  output logic                     o_in_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DATA_W-1:0] o_data,
  output logic [5:0]               o_index,
  output logic                     o_sop,
  output logic                     o_eop,
  output logic                     o_overflow
);

  logic signed [DATA_W-1:0] in_data [8];
  logic signed [DATA_W-1:0] mem_q [2][DCT_BLK_SZ];

  bank_idx_t  wr_bank_q, wr_bank_d;
  bank_idx_t  rd_bank_q, rd_bank_d;
  logic [2:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] bank_full_q, bank_full_d;
  rd_state_e  state_q, state_d;
  logic       overflow_q, overflow_d;

  logic                     valid_q, valid_d;
  logic signed [DATA_W-1:0] data_q, data_d;
  scan_idx_t                index_q, index_d;
  logic                     sop_q, sop_d;
  logic                     eop_q, eop_d;

  logic                     wr_en;
  logic                     load;
  logic                     release_bank;
  bank_idx_t                rd_sel;
  scan_idx_t                rd_pos;
  scan_idx_t                rd_addr;
  logic signed [DATA_W-1:0] rd_word;

  assign in_data = '{i_data0, i_data1, i_data2, i_data3, i_data4, i_data5, i_data6, i_data7};

  assign o_in_ready = ~bank_full_q[wr_bank_q];
  assign wr_en      = i_valid & o_in_ready;

`ifdef DCT_ZIGZAG_EN
  logic [2:0] zz_row, zz_col;

  dct_zigzag_rom u_zigzag_rom (
    .pos_i (rd_pos),
    .row_o (zz_row),
    .col_o (zz_col)
  );

  assign rd_addr = {zz_row, zz_col};
`else
  assign rd_addr = rd_pos;
`endif

  // Single read port: only one (bank, address) pair is looked up per cycle.
  assign rd_word = mem_q[rd_sel][rd_addr];

  // Control: write side, bank flags and read FSM.
  always_comb begin
    beat_cnt_d   = beat_cnt_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    bank_full_d  = bank_full_q;
    overflow_d   = overflow_q;
    state_d      = state_q;
    load         = 1'b0;
    release_bank = 1'b0;
    rd_sel       = rd_bank_q;
    rd_pos       = index_q + 6'd1;

    if (i_valid) begin
      if (o_in_ready) begin
        beat_cnt_d = beat_cnt_q + 3'd1;
        if (beat_cnt_q == 3'd7) begin
          bank_full_d[wr_bank_q] = 1'b1;
          wr_bank_d              = ~wr_bank_q;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          rd_pos  = '0;
          load    = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (valid_q && i_ready) begin
          if (index_q != 6'd63) begin
            load = 1'b1;
          end else begin
            release_bank = 1'b1;
            rd_bank_d    = ~rd_bank_q;
            if (bank_full_q[~rd_bank_q]) begin
              rd_sel = ~rd_bank_q;
              rd_pos = '0;
              load   = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A bank being written is never full, so this cannot clash with the set above.
    if (release_bank) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
  end

  // Output registers: load a coefficient, hold while stalled, or clear on going idle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    index_d = index_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = rd_word;
      index_d = rd_pos;
      sop_d   = (rd_pos == 6'd0);
      eop_d   = (rd_pos == 6'd63);
    end else if (release_bank) begin
      valid_d = 1'b0;
      data_d  = '0;
      index_d = '0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      beat_cnt_q  <= '0;
      bank_full_q <= '0;
      state_q     <= ST_IDLE;
      overflow_q  <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      index_q     <= '0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      beat_cnt_q  <= beat_cnt_d;
      bank_full_q <= bank_full_d;
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      index_q     <= index_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
    end
  end

  // Block store carries no reset; stale contents are unreachable once the flags clear.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      for (int r = 0; r < N; r++) begin
        mem_q[wr_bank_q][{3'(r), beat_cnt_q}] <= in_data[r];
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_index    = index_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_dct_coef_serializer.sv
// Directed bench for dct_coef_serializer: reset, raster/zigzag order, backpressure,
// ping-pong streaming, overflow and mid-block reset.
module tb_dct_coef_serializer;

  localparam int DW = 12;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 i_ready = 1'b0;
  logic signed [DW-1:0] d [8];
  logic                 o_in_ready, o_valid, o_sop, o_eop, o_overflow;
  logic signed [DW-1:0] o_data;
  logic [5:0]           o_index;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q [$];

  typedef struct {
    logic       rst_n;
    logic       valid;
    int         beat;
    logic       ready;
    logic       e_valid;
    logic       e_inr;
    logic       e_ovf;
    int         e_idx;
    logic       e_sop;
    int         e_data;
  } vec_t;

  vec_t tbl [13];

`ifdef DCT_ZIGZAG_EN
  int zz [64] = '{
    0,  1,  8,  16, 9,  2,  3,  10, 17, 24, 32, 25, 18, 11, 4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6,  7,  14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };
`endif

  dct_coef_serializer dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .i_data0    (d[0]),
    .i_data1    (d[1]),
    .i_data2    (d[2]),
    .i_data3    (d[3]),
    .i_data4    (d[4]),
    .i_data5    (d[5]),
    .i_data6    (d[6]),
    .i_data7    (d[7]),
    .o_in_ready (o_in_ready),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data     (o_data),
    .o_index    (o_index),
    .o_sop      (o_sop),
    .o_eop      (o_eop),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  function automatic int scan_addr(input int p);
`ifdef DCT_ZIGZAG_EN
    return zz[p];
`else
    return p;
`endif
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_beat(input int base, input int k);
    for (int r = 0; r < 8; r++) d[r] = 12'(base + r * 8 + k);
  endtask

  // Send one block, waiting (bounded) for o_in_ready before each beat.
  task automatic send_block(input int base);
    int b;
    exp_q.push_back(base);
    for (int k = 0; k < 8; k++) begin
      b = 0;
      i_valid = 1'b0;
      while (!o_in_ready && b < 500) begin
        tick();
        b++;
      end
      if (!o_in_ready) check("in_ready_wait_timeout", 0, 1);
      drive_beat(base, k);
      i_valid = 1'b1;
      tick();
    end
    i_valid = 1'b0;
  endtask

  // Consume nblk blocks; mode 0 = always ready, mode 1 = ready toggles each cycle.
  task automatic consume(input int nblk, input int mode, input bit chk_gap);
    int got = 0, pos = 0, gap = 0, budget = 0, cur_base = 0;
    logic prev_stall = 1'b0;
    int pd = 0, pi = 0;
    i_ready = 1'b1;
    while (got < nblk * 64 && budget < nblk * 400) begin
      if (prev_stall) begin
        check("stall_valid", int'(o_valid), 1);
        check("stall_data", int'(o_data), pd);
        check("stall_index", int'(o_index), pi);
      end
      if (o_valid && i_ready) begin
        if (pos == 0) begin
          if (exp_q.size() == 0) check("unexpected_block", 1, 0);
          else cur_base = exp_q.pop_front();
          if (chk_gap && got > 0) check("no_bubble_gap", gap, 1);
        end
        check("data", int'(o_data), cur_base + scan_addr(pos));
        check("index", int'(o_index), pos);
        check("sop", int'(o_sop), int'(pos == 0));
        check("eop", int'(o_eop), int'(pos == 63));
        pos = (pos + 1) % 64;
        got++;
        gap = 0;
      end
      prev_stall = o_valid && !i_ready;
      pd = int'(o_data);
      pi = int'(o_index);
      tick();
      gap++;
      budget++;
      if (mode == 1) i_ready = ~i_ready;
    end
    if (got < nblk * 64) check("consume_timeout", got, nblk * 64);
    i_ready = 1'b0;
  endtask

  initial begin
    int b;
    for (int r = 0; r < 8; r++) d[r] = '0;

    // Reset, idle, one block of beats, then first output after two edges.
    for (int i = 0; i < 13; i++) begin
      tbl[i] = '{rst_n: 1'b1, valid: 1'b0, beat: 0, ready: 1'b0, e_valid: 1'b0,
                 e_inr: 1'b1, e_ovf: 1'b0, e_idx: 0, e_sop: 1'b0, e_data: 0};
    end
    for (int i = 0; i < 3; i++) tbl[i].rst_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tbl[4 + k].valid = 1'b1;
      tbl[4 + k].beat  = k;
    end
    tbl[12].e_valid = 1'b1;
    tbl[12].e_sop   = 1'b1;

    for (int i = 0; i < 13; i++) begin
      i_rst   = tbl[i].rst_n;
      i_valid = tbl[i].valid;
      i_ready = tbl[i].ready;
      drive_beat(0, tbl[i].beat);
      tick();
      check($sformatf("tbl%0d_valid", i), int'(o_valid), int'(tbl[i].e_valid));
      check($sformatf("tbl%0d_in_ready", i), int'(o_in_ready), int'(tbl[i].e_inr));
      check($sformatf("tbl%0d_overflow", i), int'(o_overflow), int'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_index", i), int'(o_index), tbl[i].e_idx);
      check($sformatf("tbl%0d_sop", i), int'(o_sop), int'(tbl[i].e_sop));
      check($sformatf("tbl%0d_data", i), int'(o_data), tbl[i].e_data);
    end
    i_valid = 1'b0;

    // Drain the table's block (data 0..63 in scan order).
    exp_q.push_back(0);
    consume(1, 0, 1'b0);
    check("idle_after_block", int'(o_valid), 0);

    // Backpressure with toggling ready.
    fork
      send_block(500);
      consume(1, 1, 1'b0);
    join
    check("idle_after_bp", int'(o_valid), 0);

    // Three blocks back-to-back: upstream throttled, no bubbles between blocks.
    fork
      begin
        send_block(1000);
        send_block(1100);
        check("in_ready_low_both_full", int'(o_in_ready), 0);
        send_block(1200);
      end
      consume(3, 0, 1'b1);
    join
    check("no_overflow_pingpong", int'(o_overflow), 0);
    check("idle_after_pingpong", int'(o_valid), 0);

    // Overflow: fill both banks with output stalled, then push an extra beat.
    i_ready = 1'b0;
    send_block(200);
    send_block(300);
    check("in_ready_low_full", int'(o_in_ready), 0);
    drive_beat(900, 0);
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("overflow_set", int'(o_overflow), 1);
    for (int i = 0; i < 3; i++) tick();
    check("overflow_sticky", int'(o_overflow), 1);
    check("stalled_index_held", int'(o_index), 0);

    // Stream part of the block, then reset at index 20.
    i_ready = 1'b1;
    b = 0;
    while (!(o_valid && o_index == 6'd20) && b < 200) begin
      tick();
      b++;
    end
    check("reached_index20", int'(o_index), 20);
    i_rst   = 1'b0;
    i_ready = 1'b0;
    exp_q.delete();
    tick();
    check("rst_mid_valid", int'(o_valid), 0);
    check("rst_mid_index", int'(o_index), 0);
    check("rst_mid_overflow", int'(o_overflow), 0);
    check("rst_mid_in_ready", int'(o_in_ready), 1);
    i_rst = 1'b1;
    tick();
    check("post_rst_idle", int'(o_valid), 0);

    // A fresh block with negative coefficients streams cleanly from index 0.
    fork
      send_block(-40);
      consume(1, 0, 1'b0);
    join
    check("final_overflow_clear", int'(o_overflow), 0);
    check("final_idle", int'(o_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
